// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronises and glitch-filters raw A/B pins, then decodes
// Gray-code transitions into a registered step pulse, a direction level and error flags.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic quad_a,
  input  logic quad_b,
  input  logic err_clr,
  output logic step,
  output logic up_down,
  output logic err,
  output logic err_sticky
);

  localparam int CNT_W  = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int INIT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {INIT, TRACK} state_t;

  state_t                state_q, state_d;
  logic [INIT_W-1:0]     init_cnt;
  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]            s_ab;            // {A, B} at the synchroniser output
  logic [1:0]            filt;            // {A, B} after the glitch filter
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0]            prev_ab;
  logic [1:0]            changed;
  logic                  step_d, err_d, dir_d;

  assign s_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], quad_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], quad_b};
    end
  end

  // A channel takes its new level only after FILT_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (state_q == INIT) begin
          filt[i] <= s_ab[i];
          cnt[i]  <= '0;
        end else if (s_ab[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(FILT_CYCLES - 1)) begin
          filt[i] <= s_ab[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      init_cnt <= '0;
      prev_ab  <= '0;
    end else begin
      state_q  <= state_d;
      init_cnt <= (state_q == INIT) ? init_cnt + 1'b1 : '0;
      prev_ab  <= (state_q == INIT) ? s_ab : filt;
    end
  end

  assign changed = filt ^ prev_ab;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = up_down;
    unique case (state_q)
      INIT: begin
        if (init_cnt == INIT_W'(SYNC_STAGES)) state_d = TRACK;
      end
      TRACK: begin
        if (changed == 2'b11) begin
          err_d = 1'b1;
        end else if (changed != 2'b00) begin
          step_d = 1'b1;
          // Moving up, A changes to differ from B and B changes to equal A.
          dir_d  = changed[1] ? (filt[1] ^ filt[0]) : ~(filt[1] ^ filt[0]);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step       <= 1'b0;
      up_down    <= 1'b1;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step    <= step_d;
      up_down <= dir_d;
      err     <= err_d;
      // Setting wins over err_clr both on the clock that raises err and while err is high.
      if (err_d || err)  err_sticky <= 1'b1;
      else if (err_clr)  err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: directed vector table, hand-written
// corner sequences, and a randomized run against a Gray-position reference model.
module tb_quad_step_decoder;

  localparam int LAT  = 6;   // pin change to step high at default parameters
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst, quad_a, quad_b, err_clr;
  logic step, up_down, err, err_sticky;

  int n_checks = 0;
  int n_errors = 0;

  quad_step_decoder dut (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b), .err_clr(err_clr),
    .step(step), .up_down(up_down), .err(err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ab;
    int         hold;
    int         steps;
    int         errs;
    logic       dir;
    logic       sticky;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive pins at a negedge, then watch for hold cycles.
  task automatic apply(input logic [1:0] ab, input int hold,
                       output int n_step, output int n_err, output int first_at);
    {quad_a, quad_b} = ab;
    n_step = 0; n_err = 0; first_at = -1;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (step) n_step++;
      if (err)  n_err++;
      if ((step || err) && first_at < 0) first_at = i;
    end
  endtask

  task automatic run_vec(input int i);
    int ns, ne, fa;
    apply(vecs[i].ab, vecs[i].hold, ns, ne, fa);
    check($sformatf("vec%0d steps", i), ns, vecs[i].steps);
    check($sformatf("vec%0d errs", i), ne, vecs[i].errs);
    check($sformatf("vec%0d up_down", i), up_down, vecs[i].dir);
    check($sformatf("vec%0d err_sticky", i), err_sticky, vecs[i].sticky);
    if (vecs[i].steps + vecs[i].errs > 0) check($sformatf("vec%0d latency", i), fa, LAT);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    rst = 1'b1;
    {quad_a, quad_b} = ab;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Position along the up sequence 00->10->11->01.
  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    int ns, ne, fa, ts, te;
    logic [1:0] pins_q[$];
    int ev[MAXC];          // 0 none, 1 up, 2 down, 3 err, indexed by check cycle
    logic [1:0] cur, nxt;
    int exp_dir, n_err_ev, delta;

    vecs[0] = '{2'b10, 10, 1, 0, 1'b1, 1'b0};
    vecs[1] = '{2'b11, 10, 1, 0, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 10, 1, 0, 1'b1, 1'b0};
    vecs[3] = '{2'b00, 10, 1, 0, 1'b1, 1'b0};
    vecs[4] = '{2'b01, 10, 1, 0, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 10, 1, 0, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 10, 1, 0, 1'b0, 1'b0};
    vecs[7] = '{2'b00, 10, 1, 0, 1'b0, 1'b0};
    vecs[8] = '{2'b11, 10, 0, 1, 1'b0, 1'b1};
    vecs[9] = '{2'b01, 10, 1, 0, 1'b1, 1'b1};

    rst = 1'b1; quad_a = 1'b0; quad_b = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset step", step, 0);
    check("reset up_down", up_down, 1);
    check("reset err", err, 0);
    check("reset err_sticky", err_sticky, 0);
    rst = 1'b0;
    apply(2'b00, 10, ns, ne, fa);
    check("init quiet", ns + ne, 0);

    // Up then down sequences, glitch, then double transition and recovery.
    for (int i = 0; i < 8; i++) run_vec(i);
    apply(2'b10, 2, ns, ne, fa);
    ts = ns; te = ne;
    apply(2'b00, 10, ns, ne, fa);
    check("glitch steps", ts + ns, 0);
    check("glitch errs", te + ne, 0);
    check("glitch up_down", up_down, 0);
    for (int i = 8; i < 10; i++) run_vec(i);

    // err_clr clears the sticky flag.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr clears", err_sticky, 0);

    // Double transition with err_clr held across the err clocks: set wins.
    apply(2'b10, LAT - 1, ns, ne, fa);
    check("pre-err quiet", ns + ne, 0);
    err_clr = 1'b1;
    @(negedge clk);
    check("err pulse", err, 1);
    check("err no step", step, 0);
    @(negedge clk);
    err_clr = 1'b0;
    check("set wins err_sticky", err_sticky, 1);
    check("err one cycle", err, 0);
    apply(2'b10, 4, ns, ne, fa);

    // Reset mid-sequence with pins at 11.
    apply(2'b00, 10, ns, ne, fa);
    check("pre-rst down step", ns, 1);
    apply(2'b01, 10, ns, ne, fa);
    apply(2'b11, 3, ns, ne, fa);
    #2 rst = 1'b1;
    #1;
    check("midrst up_down", up_down, 1);
    check("midrst err_sticky", err_sticky, 0);
    check("midrst step", step, 0);
    check("midrst err", err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    apply(2'b11, 12, ns, ne, fa);
    check("post-rst INIT steps", ns, 0);
    check("post-rst INIT errs", ne, 0);
    apply(2'b10, 10, ns, ne, fa);
    check("post-rst step", ns, 1);
    check("post-rst latency", fa, LAT);
    check("post-rst up_down", up_down, 0);

    // Randomized run: pin levels held >= FILT_CYCLES+1, glitches shorter than FILT_CYCLES.
    do_reset(2'b00);
    apply(2'b00, 12, ns, ne, fa);
    for (int c = 0; c < MAXC; c++) ev[c] = 0;
    cur = 2'b00;
    n_err_ev = 0;
    for (int seg = 0; seg < 60; seg++) begin
      int r, hold;
      r    = $urandom_range(0, 9);
      hold = $urandom_range(4, 9);
      if (r < 2) begin
        nxt = $urandom_range(0, 1) ? 2'b10 : 2'b01;
        repeat ($urandom_range(1, 2)) pins_q.push_back(cur ^ nxt);
        repeat (hold) pins_q.push_back(cur);
      end else begin
        nxt   = (r < 4) ? ~cur : cur ^ ($urandom_range(0, 1) ? 2'b10 : 2'b01);
        delta = (gray_pos(nxt) - gray_pos(cur) + 4) % 4;
        ev[pins_q.size() + LAT] = (delta == 1) ? 1 : (delta == 3) ? 2 : 3;
        if (delta == 2) n_err_ev++;
        repeat (hold) pins_q.push_back(nxt);
        cur = nxt;
      end
    end
    exp_dir = 1;
    for (int c = 0; c < pins_q.size() + LAT + 2; c++) begin
      @(negedge clk);
      if (ev[c] == 1) exp_dir = 1;
      if (ev[c] == 2) exp_dir = 0;
      check($sformatf("rand c%0d step", c), step, int'(ev[c] == 1 || ev[c] == 2));
      check($sformatf("rand c%0d err", c), err, int'(ev[c] == 3));
      check($sformatf("rand c%0d up_down", c), up_down, exp_dir);
      if (c < pins_q.size()) {quad_a, quad_b} = pins_q[c];
    end
    check("rand err_sticky", err_sticky, int'(n_err_ev > 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
